// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding, default parameters and counter sizing for the LCD scheduler
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } lcd_state_e;

    localparam int LCD_N_REQ_DEF       = 4;
    localparam int LCD_REFRESH_CYC_DEF = 50_000_000;
    localparam int LCD_TIMEOUT_CYC_DEF = 1_000_000;

    // Width able to hold 0..v; never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/lcd_sched_if.sv
// rtl/lcd_sched_if.sv - requester and LCD-controller signal bundle for lcd_sched
interface lcd_sched_if
    import lcd_pkg::*;
#(
    parameter int N_REQ = LCD_N_REQ_DEF
) ();
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    I_REQ;
    logic [N_REQ*32-1:0] I_DATA;
    logic [N_REQ-1:0]    O_ACK;
    logic                O_START;
    logic [31:0]         O_REG_DATA;
    logic                I_DONE;
    logic [IW-1:0]       O_SEL;
    logic                O_BUSY;
    logic                O_TIMEOUT;

    modport slave (
        input  I_REQ, I_DATA, I_DONE,
        output O_ACK, O_START, O_REG_DATA, O_SEL, O_BUSY, O_TIMEOUT
    );

    modport master (
        output I_REQ, I_DATA, I_DONE,
        input  O_ACK, O_START, O_REG_DATA, O_SEL, O_BUSY, O_TIMEOUT
    );
endinterface

// File: rtl/lcd_sched_rr_arb.sv
// rtl/lcd_sched_rr_arb.sv - combinational round-robin search starting just above the pointer
module rr_arb #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/lcd_sched.sv
// rtl/lcd_sched.sv - round-robin scheduler feeding register values to an LCD display controller,
// with idle refresh and WAIT timeout.
module lcd_sched
    import lcd_pkg::*;
#(
    parameter int N_REQ       = LCD_N_REQ_DEF,
    parameter int REFRESH_CYC = LCD_REFRESH_CYC_DEF,
    parameter int TIMEOUT_CYC = LCD_TIMEOUT_CYC_DEF
) (
    input logic        I_CLK,
    input logic        I_RSTF,
    lcd_sched_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int RW = cnt_w(REFRESH_CYC);
    localparam int TW = cnt_w(TIMEOUT_CYC);

    lcd_state_e       state_q;
    logic             start_q, tmo_q, busy_q, refresh_q;
    logic [N_REQ-1:0] ack_q;
    logic [IW-1:0]    sel_q;
    logic [31:0]      data_q;
    logic [RW-1:0]    rcnt_q;
    logic [TW-1:0]    wcnt_q;

    logic [N_REQ-1:0] gnt, sel_oh, mux_oh;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_vld, rfr_exp, tmo_exp;
    logic [31:0]      mux_data;

    rr_arb #(.N(N_REQ)) u_arb (
        .req_i (bus.I_REQ),
        .ptr_i (sel_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign sel_oh  = N_REQ'(1) << sel_q;
    assign rfr_exp = (REFRESH_CYC != 0) && (int'(rcnt_q) + 1 >= REFRESH_CYC);
    assign tmo_exp = (int'(wcnt_q) + 1 >= TIMEOUT_CYC);

    // A new grant samples the winner; a refresh re-samples the last served requester.
    always_comb begin
        mux_oh   = gnt_vld ? gnt : sel_oh;
        mux_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (mux_oh[i]) mux_data = mux_data | bus.I_DATA[32*i +: 32];
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            ack_q     <= '0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            refresh_q <= 1'b0;
            sel_q     <= IW'(N_REQ - 1);
            data_q    <= '0;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            tmo_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld || rfr_exp) begin
                        if (gnt_vld) sel_q <= gnt_idx;
                        refresh_q <= !gnt_vld;
                        data_q    <= mux_data;
                        rcnt_q    <= '0;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LAUNCH;
                    end else if (rcnt_q != '1) begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    wcnt_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion beats a timeout expiring in the same cycle.
                    if (bus.I_DONE || tmo_exp) begin
                        ack_q   <= refresh_q ? '0 : sel_oh;
                        tmo_q   <= !bus.I_DONE && !refresh_q;
                        wcnt_q  <= '0;
                        state_q <= ST_ACK;
                    end else if (wcnt_q != '1) begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.O_START    = start_q;
    assign bus.O_ACK      = ack_q;
    assign bus.O_TIMEOUT  = tmo_q;
    assign bus.O_BUSY     = busy_q;
    assign bus.O_SEL      = sel_q;
    assign bus.O_REG_DATA = data_q;
endmodule

// File: doc/lcd_sched.md
LCD_SCHED -- requirements
Module: lcd_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter REFRESH_CYC, default 50_000_000: idle cycles before an automatic re-display; 0 disables refresh.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000: WAIT-state cycles before the transaction is abandoned.
REQ-004 I_CLK  in  1  system clock; all logic is on the rising edge.
REQ-005 I_RSTF  in  1  asynchronous, active-low reset.
REQ-006 I_REQ  in  N_REQ  per-requester level request, held until its O_ACK.
REQ-007 I_DATA  in  N_REQ*32  per-requester 32-bit register value; requester i uses bits [32i+31:32i].
REQ-008 O_ACK  out  N_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-009 O_START  out  1  one-cycle start pulse to the LCD display controller.
REQ-010 O_REG_DATA  out  32  value to display; stable from O_START until I_DONE.
REQ-011 I_DONE  in  1  one-cycle completion pulse from the LCD display controller.
REQ-012 O_SEL  out  clog2(N_REQ)  index of the requester currently or last served.
REQ-013 O_BUSY  out  1  high in every state except IDLE.
REQ-014 O_TIMEOUT  out  1  one-cycle pulse, coincident with O_ACK, when a transaction is abandoned.

Function
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, WAIT and ACK; state encoding is free.
REQ-016 In IDLE with any I_REQ bit high at cycle t, the block SHALL grant one round-robin winner and register O_SEL and O_REG_DATA from that requester's I_DATA, then enter LAUNCH at t+1.
REQ-017 Round-robin search SHALL start at O_SEL+1 and ascend with wrap-around; after reset requester 0 has highest priority (pointer = N_REQ-1).
REQ-018 In LAUNCH, O_START=1 for exactly one cycle, then WAIT; grant-to-O_START latency is 1 cycle.
REQ-019 I_DONE SHALL be honoured only in WAIT; I_DONE in any other state is ignored.
REQ-020 I_DONE in WAIT at cycle d SHALL cause ACK at d+1, with O_ACK[O_SEL]=1, then IDLE at d+2.
REQ-021 Requester-to-next-grant minimum turnaround is 1 IDLE cycle; back-to-back requests SHALL still alternate round-robin.
REQ-022 An I_REQ bit dropped before its grant SHALL be ignored; a drop after grant SHALL not abort the transaction, and O_ACK is still issued.
REQ-023 Changes on I_DATA after the grant SHALL not affect O_REG_DATA until the next grant.
REQ-024 The refresh counter SHALL count only in IDLE with no request and reload on leaving IDLE.
REQ-025 On refresh expiry, the block SHALL re-grant the current O_SEL (re-sample its I_DATA), perform LAUNCH and WAIT, and return through ACK with O_ACK all-zero.
REQ-026 When a request and refresh expiry coincide, the request SHALL win, and the refresh counter reloads.
REQ-027 The WAIT cycle counter SHALL reach TIMEOUT_CYC, then enter ACK with O_TIMEOUT=1 and O_ACK[O_SEL]=1, on a non-refresh transaction.
REQ-028 I_DONE arriving on the same cycle as timeout expiry SHALL take priority, with O_TIMEOUT=0.
REQ-029 Counter widths SHALL be sized by clog2 of their parameter; counters saturate and never wrap.

Reset
REQ-030 The asynchronous reset SHALL force: state IDLE, O_START=0, O_ACK=0, O_TIMEOUT=0, O_BUSY=0, O_SEL=N_REQ-1, O_REG_DATA=0, and both counters reloaded.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no O_ACK issued; requesters re-arbitrate after release.
REQ-032 The first grant SHALL be possible on the first clock edge after I_RSTF deasserts.

Structure
REQ-033 The state enumeration and default parameter values SHALL live in a shared package, lcd_pkg, which lcd_if-family blocks may import.
REQ-034 The round-robin priority search SHALL be one sub-module, rr_arb (inputs: request vector and pointer; output: one-hot grant plus index), and SHALL be purely combinational.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Single request: I_REQ=4'b0010 with I_DATA[1]=32'hDEADBEEF -> O_START one cycle after grant with O_REG_DATA=DEADBEEF, and O_SEL=1; I_DONE five cycles later -> O_ACK=4'b0010 the next cycle.
REQ-037 Fairness: I_REQ=4'b1111 held, with I_DONE after every O_START -> grant order 0,1,2,3,0 and no requester starved.
REQ-038 Refresh: REFRESH_CYC=100, no requests after serving requester 2 -> O_START at idle cycle 100 with O_SEL=2 and O_ACK=0; a request on the expiry cycle wins instead.
REQ-039 Timeout: TIMEOUT_CYC=20 and I_DONE withheld -> O_TIMEOUT and O_ACK pulse together 21 cycles after O_START; I_DONE on the expiry cycle gives O_TIMEOUT=0.
REQ-040 Reset in WAIT -> all outputs reach their reset values immediately, no O_ACK, and O_SEL=3.
REQ-041 A stray I_DONE in IDLE is ignored; an I_REQ dropped after grant still receives O_ACK.
